sccb_master: RTL and testbench

- Parametrised SCCB master that runs complete 3-phase write and 2+2-phase read transactions to a camera sensor register.
- Sits between the sensor init/config sequencer and the SIO_C/SIO_D pads.
- Replaces the fixed-rate clock-only generator with a full transaction engine: configurable bus rate, 8- or 16-bit sub-address, read-back, and a start/busy/done handshake.

---
 rtl/sccb_master.sv | 276 +++++++++++++++++++++++++++
 tb/tb_sccb_master.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sccb_master.sv
// SCCB master: runs complete 3-phase writes and 2+2-phase reads to a camera
// sensor register. One bit period is four quarters of DIVIDER clk_24 cycles.
// SIO_C is low in Q0-Q1 and high in Q2-Q3. Data changes at the Q1 boundary
// and is sampled at the Q3 boundary.
module sccb_master #(
    parameter int unsigned INPUT_CLK  = 24_000_000,
    parameter int unsigned BUS_CLK    = 400_000,
    parameter int unsigned DIVIDER    = INPUT_CLK / BUS_CLK / 4,
    parameter int unsigned SUB_ADDR_W = 8,
    parameter logic [7:0]  DEVICE_ID  = 8'h42,
    parameter int unsigned IDLE_GAP   = 2
) (
    input  logic                  clk_24,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  rw,
    input  logic [SUB_ADDR_W-1:0] sub_addr,
    input  logic [7:0]            wdata,
    output logic                  busy,
    output logic                  done,
    output logic [7:0]            rdata,
    output logic                  sio_c,
    output logic                  sio_d_o,
    output logic                  sio_d_oe,
    input  logic                  sio_d_i
);

    localparam int unsigned CNT_W = $clog2(DIVIDER);
    localparam int unsigned NSUB  = SUB_ADDR_W / 8;
    localparam int unsigned PAY_W = SUB_ADDR_W + 8;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_PRE  = CNT_W'(DIVIDER - 2);
    // Bytes following the ID byte: sub-address bytes, plus wdata for writes.
    localparam logic [1:0]       BYTES_RD = 2'(NSUB);
    localparam logic [1:0]       BYTES_WR = 2'(NSUB + 1);
    localparam logic [7:0]       GAP_LAST = 8'(IDLE_GAP - 1);

    typedef enum logic [2:0] {
        StIdle, StStart, StTxByte, StDontCare, StRxByte, StNa, StStop, StGap
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       qtr_q, qtr_d;
    logic [7:0]       bit_q, bit_d;
    logic [1:0]       byte_q, byte_d;
    logic [7:0]       sh_q, sh_d;
    logic [PAY_W-1:0] pay_q, pay_d;
    logic             rw_q, rw_d;
    logic             rdph_q, rdph_d;
    logic             d_q, d_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       rdata_q, rdata_d;

    logic wrap;
    logic bit_end;
    logic enter_q1;
    logic enter_q2;
    logic enter_q3;

    // Quarter boundary events derived from the timing base.
    always_comb begin
        wrap     = (cnt_q == CNT_LAST);
        enter_q1 = wrap && (qtr_q == 2'd0);
        enter_q2 = wrap && (qtr_q == 2'd1);
        enter_q3 = wrap && (qtr_q == 2'd2);
        bit_end  = wrap && (qtr_q == 2'd3);
    end

    // State and datapath registers; reset aborts without a STOP.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            qtr_q   <= 2'd0;
            bit_q   <= 8'd0;
            byte_q  <= 2'd0;
            sh_q    <= 8'd0;
            pay_q   <= '0;
            rw_q    <= 1'b0;
            rdph_q  <= 1'b0;
            d_q     <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            qtr_q   <= qtr_d;
            bit_q   <= bit_d;
            byte_q  <= byte_d;
            sh_q    <= sh_d;
            pay_q   <= pay_d;
            rw_q    <= rw_d;
            rdph_q  <= rdph_d;
            d_q     <= d_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    // Next-state logic: sequencing of bits, bytes and phases.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        qtr_d   = qtr_q;
        bit_d   = bit_q;
        byte_d  = byte_q;
        sh_d    = sh_q;
        pay_d   = pay_q;
        rw_d    = rw_q;
        rdph_d  = rdph_q;
        d_d     = d_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;

        // Timing base runs in every state except IDLE, where it stays at zero.
        if (state_q != StIdle) begin
            cnt_d = wrap ? '0 : cnt_q + 1'b1;
            if (wrap) begin
                qtr_d = qtr_q + 2'd1;
            end
        end

        case (state_q)
            StIdle: begin
                // A start coinciding with the done pulse is deliberately dropped.
                if (start && !done_q) begin
                    state_d = StStart;
                    busy_d  = 1'b1;
                    rw_d    = rw;
                    pay_d   = {sub_addr, wdata};
                    rdph_d  = 1'b0;
                end
            end
            StStart: begin
                if (enter_q1) begin
                    d_d = 1'b0;
                end
                if (bit_end) begin
                    state_d = StTxByte;
                    sh_d    = rdph_q ? (DEVICE_ID | 8'h01) : DEVICE_ID;
                    bit_d   = 8'd0;
                    byte_d  = 2'd0;
                end
            end
            StTxByte: begin
                if (enter_q1) begin
                    d_d = sh_q[7];
                end
                if (bit_end) begin
                    sh_d = {sh_q[6:0], 1'b0};
                    if (bit_q == 8'd7) begin
                        state_d = StDontCare;
                        bit_d   = 8'd0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            StDontCare: begin
                if (bit_end) begin
                    if (rdph_q) begin
                        state_d = StRxByte;
                        bit_d   = 8'd0;
                    end else if (byte_q == (rw_q ? BYTES_RD : BYTES_WR)) begin
                        state_d = StStop;
                        d_d     = 1'b0;
                    end else begin
                        state_d = StTxByte;
                        sh_d    = pay_q[PAY_W-1 -: 8];
                        pay_d   = pay_q << 8;
                        byte_d  = byte_q + 2'd1;
                    end
                end
            end
            StRxByte: begin
                if (enter_q3) begin
                    sh_d = {sh_q[6:0], sio_d_i};
                end
                if (bit_end) begin
                    if (bit_q == 8'd7) begin
                        state_d = StNa;
                        bit_d   = 8'd0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            StNa: begin
                if (enter_q1) begin
                    d_d = 1'b1;
                end
                if (bit_end) begin
                    state_d = StStop;
                    d_d     = 1'b0;
                end
            end
            StStop: begin
                if (enter_q2) begin
                    d_d = 1'b1;
                end
                if (rw_q && !rdph_q) begin
                    if (bit_end) begin
                        bit_d = 8'd0;
                        if (IDLE_GAP == 0) begin
                            state_d = StStart;
                            rdph_d  = 1'b1;
                        end else begin
                            state_d = StGap;
                        end
                    end
                end else if ((qtr_q == 2'd3) && (cnt_q == CNT_PRE)) begin
                    // Leave one cycle early: the done cycle is the last cycle
                    // of the STOP bit, and IDLE drives the same pad levels.
                    state_d = StIdle;
                    cnt_d   = '0;
                    qtr_d   = 2'd0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    if (rw_q) begin
                        rdata_d = sh_q;
                    end
                end
            end
            StGap: begin
                if (bit_end) begin
                    if (bit_q == GAP_LAST) begin
                        state_d = StStart;
                        rdph_d  = 1'b1;
                        bit_d   = 8'd0;
                    end else begin
                        bit_d = bit_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Pad clock and output-enable decode from state and quarter.
    always_comb begin
        sio_c    = 1'b1;
        sio_d_oe = 1'b1;
        case (state_q)
            StIdle, StGap: begin
                sio_c = 1'b1;
            end
            StStart: begin
                sio_c = (qtr_q != 2'd3);
            end
            StStop: begin
                sio_c = (qtr_q != 2'd0);
            end
            StDontCare, StRxByte: begin
                sio_c    = qtr_q[1];
                sio_d_oe = 1'b0;
            end
            default: begin
                sio_c = qtr_q[1];
            end
        endcase
    end

    assign sio_d_o = d_q;
    assign busy    = busy_q;
    assign done    = done_q;
    assign rdata   = rdata_q;

endmodule

// File: tb/tb_sccb_master.sv
// Scoreboard bench for sccb_master. Three instances: 8-bit sub-address at
// 400 kHz, 16-bit sub-address at 400 kHz, and 8-bit at 100 kHz. One instance
// is selected at a time. A bus monitor decodes SIO_C/SIO_D into tokens, and
// on every done pulse it compares those tokens, latency and rdata against
// the expectations queued when the stimulus was issued.
module tb_sccb_master;

    localparam int TOK_S   = 'h1000;
    localparam int TOK_P   = 'h2000;
    localparam int TOK_END = 'h4000;
    // Token for a written byte: 9th bit released (oe=0, pull-up reads 1).
    localparam int WB      = 'h500;

    typedef struct {
        int lat;
        int per;
        int rd;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        rw;
    logic [15:0] sub_addr;
    logic [7:0]  wdata;
    logic        sio_d_i;
    logic [1:0]  sel;

    logic [2:0]  start_v;
    logic [2:0]  busy_v;
    logic [2:0]  done_v;
    logic [2:0]  c_v;
    logic [2:0]  d_v;
    logic [2:0]  oe_v;
    logic [7:0]  rdata_v [3];

    logic        m_busy;
    logic        m_done;
    logic        m_c;
    logic        m_d;
    logic        m_oe;
    logic [7:0]  m_rdata;

    exp_t exp_q[$];
    int   exp_tok[$];
    int   got_tok[$];
    int   n_total;
    int   n_pass;

    // Sensor model state, written by the monitor.
    logic       sens_on;
    int         grp;
    int         bitn;
    logic [7:0] sdat;

    sccb_master #(.SUB_ADDR_W(8)) u_dut0 (
        .clk_24(clk), .reset_n(reset_n), .start(start_v[0]), .rw(rw),
        .sub_addr(sub_addr[7:0]), .wdata(wdata), .busy(busy_v[0]), .done(done_v[0]),
        .rdata(rdata_v[0]), .sio_c(c_v[0]), .sio_d_o(d_v[0]), .sio_d_oe(oe_v[0]),
        .sio_d_i(sio_d_i)
    );

    sccb_master #(.SUB_ADDR_W(16)) u_dut1 (
        .clk_24(clk), .reset_n(reset_n), .start(start_v[1]), .rw(rw),
        .sub_addr(sub_addr), .wdata(wdata), .busy(busy_v[1]), .done(done_v[1]),
        .rdata(rdata_v[1]), .sio_c(c_v[1]), .sio_d_o(d_v[1]), .sio_d_oe(oe_v[1]),
        .sio_d_i(sio_d_i)
    );

    sccb_master #(.BUS_CLK(100_000)) u_dut2 (
        .clk_24(clk), .reset_n(reset_n), .start(start_v[2]), .rw(rw),
        .sub_addr(sub_addr[7:0]), .wdata(wdata), .busy(busy_v[2]), .done(done_v[2]),
        .rdata(rdata_v[2]), .sio_c(c_v[2]), .sio_d_o(d_v[2]), .sio_d_oe(oe_v[2]),
        .sio_d_i(sio_d_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always_comb begin
        start_v = 3'b000;
        if (start) start_v[sel] = 1'b1;
    end

    assign m_busy  = busy_v[sel];
    assign m_done  = done_v[sel];
    assign m_c     = c_v[sel];
    assign m_d     = d_v[sel];
    assign m_oe    = oe_v[sel];
    assign m_rdata = rdata_v[sel];

    // Sensor drives the data byte MSB first after the read ID, otherwise pull-up.
    always_comb begin
        sio_d_i = 1'b1;
        if (sens_on && grp == 1 && bitn < 8) sio_d_i = sdat[7-bitn];
    end

    task automatic chk(input string name, input int got, input int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, want);
    endtask

    task automatic push_exp(input int lat, input int per, input int rd);
        exp_t e;
        e.lat = lat;
        e.per = per;
        e.rd  = rd;
        exp_q.push_back(e);
    endtask

    task automatic exp_write(input int lat, input int per, input int rd, input int nsub,
                             input logic [15:0] sub, input logic [7:0] wd);
        push_exp(lat, per, rd);
        exp_tok.push_back(TOK_S);
        exp_tok.push_back(WB | 'h42);
        if (nsub == 2) exp_tok.push_back(WB | int'(sub[15:8]));
        exp_tok.push_back(WB | int'(sub[7:0]));
        exp_tok.push_back(WB | int'(wd));
        exp_tok.push_back(TOK_P);
        exp_tok.push_back(TOK_END);
    endtask

    task automatic go(input logic rw_i, input logic [15:0] sub, input logic [7:0] wd);
        start    = 1'b1;
        rw       = rw_i;
        sub_addr = sub;
        wdata    = wd;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit);
        int k;
        k = 0;
        while (!m_done && k < limit) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("done_timeout", int'(m_done), 1);
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_sio_c"}, int'(m_c), 1);
        chk({tag, "_sio_d_o"}, int'(m_d), 1);
        chk({tag, "_sio_d_oe"}, int'(m_oe), 1);
        chk({tag, "_busy"}, int'(m_busy), 0);
        chk({tag, "_done"}, int'(m_done), 0);
        chk({tag, "_rdata"}, int'(m_rdata), 0);
    endtask

    // Monitor: decodes the bus on the falling clock edge and scores on done.
    initial begin
        int cyc, t0, busy_cnt, stop_cyc, last_fall, per, tok, x, g;
        bit seen_stop, skip_fall, in_seg;
        logic pc, pb, po, pbusy, pdone, bus, oor;
        logic [7:0] acc;
        exp_t e;
        cyc = 0; t0 = 0; busy_cnt = 0; stop_cyc = 0; last_fall = 0; per = 0;
        seen_stop = 0; skip_fall = 0; in_seg = 0;
        pc = 1; pb = 1; po = 1; pbusy = 0; pdone = 0; oor = 0; acc = 0;
        sens_on = 0; grp = 0; bitn = 0;
        forever begin
            @(negedge clk);
            cyc++;
            bus = m_oe ? m_d : sio_d_i;
            if (!reset_n) begin
                got_tok.delete();
                sens_on = 0; grp = 0; bitn = 0; in_seg = 0; seen_stop = 0; skip_fall = 0;
                busy_cnt = 0; pc = 1; pb = 1; po = 1; pbusy = 0; pdone = 0;
                continue;
            end
            if (m_busy && !pbusy) begin
                t0 = cyc;
                busy_cnt = 0;
            end
            if (m_busy) busy_cnt++;
            if (pc && m_c && pb && !bus) begin
                got_tok.push_back(TOK_S | (seen_stop ? cyc - stop_cyc : 0));
                in_seg = 1; skip_fall = 1; grp = 0; bitn = 0; acc = 0; oor = 0; sens_on = 0;
            end else if (pc && m_c && !pb && bus) begin
                got_tok.push_back(TOK_P);
                seen_stop = 1; stop_cyc = cyc; in_seg = 0; sens_on = 0;
            end else if (pc && !m_c) begin
                per = cyc - last_fall;
                last_fall = cyc;
                if (skip_fall) begin
                    skip_fall = 0;
                end else if (in_seg) begin
                    if (bitn < 8) begin
                        acc = {acc[6:0], pb};
                        oor = oor | po;
                        bitn++;
                    end else begin
                        tok = int'({oor, po, pb, acc});
                        got_tok.push_back(tok);
                        if (grp == 0 && acc == 8'h43) sens_on = 1;
                        grp++; bitn = 0; acc = 0; oor = 0;
                    end
                end
            end
            if (m_done) begin
                chk("done_single_pulse", int'(pdone), 0);
                chk("done_expected", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("latency", cyc - t0 + 1, e.lat);
                    chk("busy_cycles", busy_cnt, e.lat - 1);
                    chk("busy_at_done", int'(m_busy), 0);
                    chk("rdata", int'(m_rdata), e.rd);
                    chk("sio_c_period", per, e.per);
                    while (exp_tok.size() > 0) begin
                        x = exp_tok.pop_front();
                        if (x == TOK_END) break;
                        g = (got_tok.size() > 0) ? got_tok.pop_front() : -1;
                        chk("bus_token", g, x);
                    end
                    chk("extra_tokens", got_tok.size(), 0);
                end
                got_tok.delete();
                seen_stop = 0;
            end
            pc = m_c; pb = bus; po = m_oe; pbusy = m_busy; pdone = m_done;
        end
    end

    // Stimulus: directed transactions with hand-computed expectations.
    initial begin
        n_total = 0; n_pass = 0;
        sdat = 8'hA5;
        reset_n = 1'b0; start = 1'b0; rw = 1'b0; sub_addr = '0; wdata = '0; sel = 2'd0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        reset_n = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // 8-bit write; junk start pulses around cycle 100 must be ignored.
        exp_write(1740, 60, 0, 1, 16'h0012, 8'h80);
        go(1'b0, 16'h0012, 8'h80);
        repeat (98) @(posedge clk);
        #1;
        start = 1'b1; rw = 1'b1; sub_addr = 16'h00FF; wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000);
        repeat (3) @(posedge clk);
        #1;

        // 8-bit read of 0x0A; sensor returns 0xA5. Gap START-to-STOP = 11*D = 165.
        push_exp(2520, 60, 'hA5);
        exp_tok.push_back(TOK_S);
        exp_tok.push_back(WB | 'h42);
        exp_tok.push_back(WB | 'h0A);
        exp_tok.push_back(TOK_P);
        exp_tok.push_back(TOK_S | 165);
        exp_tok.push_back(WB | 'h43);
        exp_tok.push_back('h3A5);
        exp_tok.push_back(TOK_P);
        exp_tok.push_back(TOK_END);
        go(1'b1, 16'h000A, 8'h00);
        wait_done(3000);
        repeat (3) @(posedge clk);
        #1;

        // Start on the done cycle is dropped; start one cycle later is taken.
        exp_write(1740, 60, 'hA5, 1, 16'h0020, 8'h5C);
        go(1'b0, 16'h0020, 8'h5C);
        wait_done(2000);
        exp_write(1740, 60, 'hA5, 1, 16'h0034, 8'h56);
        start = 1'b1; rw = 1'b1; sub_addr = 16'h0077; wdata = 8'h00;
        @(posedge clk);
        #1;
        rw = 1'b0; sub_addr = 16'h0034; wdata = 8'h56;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(2000);
        repeat (3) @(posedge clk);
        #1;

        // Reset during RX_BYTE of a read, then a clean write.
        go(1'b1, 16'h000A, 8'h00);
        repeat (2000) @(posedge clk);
        #1;
        reset_n = 1'b0;
        #1;
        chk_idle("abort");
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        exp_write(1740, 60, 0, 1, 16'h0012, 8'h80);
        go(1'b0, 16'h0012, 8'h80);
        wait_done(2000);
        repeat (3) @(posedge clk);
        #1;

        // 16-bit sub-address write.
        sel = 2'd1;
        #1;
        exp_write(2280, 60, 0, 2, 16'h3008, 8'h55);
        go(1'b0, 16'h3008, 8'h55);
        wait_done(3000);
        repeat (3) @(posedge clk);
        #1;

        // 100 kHz bus: DIVIDER = 60.
        sel = 2'd2;
        #1;
        exp_write(6960, 240, 0, 1, 16'h0012, 8'h80);
        go(1'b0, 16'h0012, 8'h80);
        wait_done(8000);
        repeat (5) @(posedge clk);
        #1;

        chk("scoreboard_drained", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
